// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//  Shared types and helpers for the bit-serial adder controller.
//  - ST_* : FSM state encodings (2-bit), also exposed as state_e.
//  - cnt_w: bit-counter width for a given operand width, max(1, clog2(width)).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // A 1-bit adder still needs a 1-bit counter.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width > 1) ? int'($clog2(width)) : 1;
    endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_fa.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_fa
//  Purely combinational 1-bit full adder cell (FA).
//  Ports: A, B, Cin : addend bits and carry-in
//         S, Cout   : sum bit and carry-out
// -----------------------------------------------------------------------------
module serial_adder_ctrl_fa (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule : serial_adder_ctrl_fa

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//  Bit-serial WIDTH-bit adder: captures a, b, cin on an accepted start, feeds
//  the FA cell one bit pair per clock (LSB first) and shifts sum bits into the
//  result register MSB-side, so after WIDTH steps sum is in natural order.
//  Ports:
//    clk, rst_n : clock (rising edge), synchronous active-low reset
//    start      : request, sampled only in IDLE
//    a, b, cin  : operands and carry-in, captured on accepted start
//    busy       : high while in RUN
//    done       : one-cycle pulse in DONE
//    sum, cout  : result and final carry, valid from done until next accept
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned      CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fa_s, fa_cout;

    // One bit pair per RUN cycle, carry recirculated through carry_q.
    serial_adder_ctrl_fa u_fa (
        .A    (a_sr_q[0]),
        .B    (b_sr_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // Next-state, datapath and registered status outputs.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            RUN: begin
                carry_d = fa_cout;
                // New bit enters at the MSB; WIDTH=1 degenerates to sum_d = fa_s.
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//  Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
//  Expected results come from plain integer addition a + b + cin.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b, sum;
    logic         cin, busy, done, cout;

    logic         start1;
    logic [0:0]   a1, b1, sum1;
    logic         cin1, busy1, done1, cout1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // Issue one add on the 8-bit DUT and wait (bounded) for done.
    // lat = edges from accept to done; bcnt = sampled cycles with busy high.
    task automatic do_add(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic icin, input bit scramble,
                          output int lat, output int bcnt,
                          output logic [W-1:0] osum, output logic ocout);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; cin = icin;
        @(negedge clk);
        start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            if (scramble) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        osum  = sum;
        ocout = cout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
        total++; if ({busy1, done1, sum1, cout1} !== 4'b0) begin
            bad++; $display("FAIL reset_w1 got=%b want=0000", {busy1, done1, sum1, cout1});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [W-1:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        int lat, bcnt;
        logic [W-1:0] gs;
        logic gc;
        logic [W:0] exp;
        for (int i = 0; i < 3; i++) begin
            do_add(va[i], vb[i], vc[i], 1'b0, lat, bcnt, gs, gc);
            exp = {1'b0, va[i]} + {1'b0, vb[i]} + (W+1)'(vc[i]);
            total++; if (lat != W) begin bad++; $display("FAIL basic_latency[%0d] got=%0d want=%0d", i, lat, W); end
            total++; if (bcnt != W) begin bad++; $display("FAIL basic_busy_cycles[%0d] got=%0d want=%0d", i, bcnt, W); end
            total++; if ({gc, gs} !== exp) begin bad++; $display("FAIL basic_result[%0d] got=%h want=%h", i, {gc, gs}, exp); end
            if (i == 0) begin
                // Result holds through the following IDLE cycle.
                @(negedge clk);
                total++; if (done !== 1'b0 || sum !== exp[W-1:0] || cout !== exp[W]) begin
                    bad++; $display("FAIL basic_hold got=%b/%h want=0/%h", done, {cout, sum}, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic [W-1:0] ra, rb, gs;
        logic rc, gc;
        logic [W:0] exp;
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            do_add(ra, rb, rc, 1'b0, lat, bcnt, gs, gc);
            exp = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            total++; if (lat != W || {gc, gs} !== exp) begin
                bad++; $display("FAIL random[%0d] got=%h lat=%0d want=%h lat=%0d", i, {gc, gs}, lat, exp, W);
            end
        end
    endtask

    // start held high: each add takes W RUN cycles, one DONE and one IDLE
    // cycle before the next accept.
    task automatic test_back_to_back();
        int n_done, n_acc, last_done, gap_err;
        logic prev_busy, prev_done;
        n_done = 0; n_acc = 0; last_done = -1; gap_err = 0;
        prev_busy = 1'b0; prev_done = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy !== 1'b1) n_acc++;
            if (done === 1'b1) begin
                n_done++;
                if (prev_done === 1'b1) gap_err++;
                if (last_done >= 0 && i - last_done != W + 2) gap_err++;
                last_done = i;
                total++; if ({cout, sum} !== 9'h034) begin
                    bad++; $display("FAIL b2b_result got=%h want=034", {cout, sum});
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
        start = 1'b0;
        total++; if (n_done != 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", n_done); end
        total++; if (n_acc != 3) begin bad++; $display("FAIL b2b_accept_count got=%0d want=3", n_acc); end
        total++; if (gap_err != 0) begin bad++; $display("FAIL b2b_spacing got=%0d errors want=0", gap_err); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt;
        logic [W-1:0] gs;
        logic gc;
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;           // 4th RUN edge sees reset
        @(negedge clk);
        total++; if ({busy, done, cout, sum} !== 11'b0) begin
            bad++; $display("FAIL midrst_clear got=%b%b%b_%h want=000_00", busy, done, cout, sum);
        end
        rst_n = 1'b1;
        do_add(8'h01, 8'h01, 1'b0, 1'b0, lat, bcnt, gs, gc);
        total++; if (lat != W || {gc, gs} !== 9'h002) begin
            bad++; $display("FAIL midrst_next got=%h lat=%0d want=002 lat=%0d", {gc, gs}, lat, W);
        end
    endtask

    task automatic test_operand_change();
        int lat, bcnt;
        logic [W-1:0] gs;
        logic gc;
        do_add(8'h10, 8'h20, 1'b0, 1'b1, lat, bcnt, gs, gc);
        total++; if (lat != W || {gc, gs} !== 9'h030) begin
            bad++; $display("FAIL opchange got=%h lat=%0d want=030 lat=%0d", {gc, gs}, lat, W);
        end
    endtask

    task automatic test_width1();
        logic [2:0] c;
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            c = 3'(i);
            @(negedge clk);
            start1 = 1'b1; a1 = c[2]; b1 = c[1]; cin1 = c[0];
            @(negedge clk);
            start1 = 1'b0;
            a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
            total++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                bad++; $display("FAIL w1_run[%0d] got busy=%b done=%b want busy=1 done=0", i, busy1, done1);
            end
            @(negedge clk);
            exp = 2'(c[2]) + 2'(c[1]) + 2'(c[0]);
            total++; if (done1 !== 1'b1 || {cout1, sum1} !== exp) begin
                bad++; $display("FAIL w1_result[%0d] got done=%b res=%b want done=1 res=%b", i, done1, {cout1, sum1}, exp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_operand_change();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
